// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port 32-bit RAM between NUM_REQ engines.
// Round-robin grants are held for a whole burst (while req stays high). A grant
// release is followed by one HANDOVER dead cycle and one IDLE cycle before the
// next grant can be issued.
// Optional feature macro: ARB_TIMEOUT_EN (bounds a grant to MAX_HOLD cycles and
// blocks a timed-out requester until it drops its request).
module ram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_HOLD   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*4-1:0]          req_we,
  input  logic [NUM_REQ*32-1:0]         req_di,
  output logic                          RAM_EN,
  output logic [ADDR_WIDTH-1:0]         RAM_A,
  output logic [3:0]                    RAM_WE,
  output logic [31:0]                   RAM_Di,
  input  logic [31:0]                   RAM_Do,
  output logic [31:0]                   rd_data,
  output logic                          timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } state_t;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_bad_param
      $error("ram_port_arbiter: NUM_REQ must be 2..8 and MAX_HOLD at least 2");
    end
  endgenerate

  // Requester index base+k wrapped modulo NUM_REQ (base < NUM_REQ, k < NUM_REQ).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return s[IDX_W-1:0];
  endfunction

  state_t               state_r, state_n;
  logic [NUM_REQ-1:0]   gnt_r, gnt_n;
  logic [IDX_W-1:0]     owner_r, owner_n;
  logic [IDX_W-1:0]     rr_ptr_r, rr_n;
  logic [NUM_REQ-1:0]   elig_s;
  logic [IDX_W-1:0]     pick_s;
  logic                 found_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0]     hold_cnt_r, hold_cnt_n;
  logic [NUM_REQ-1:0]   blocked_r, blocked_n;
  logic                 timeout_r, timeout_n;

  assign elig_s  = req & ~blocked_r;
  assign timeout = timeout_r;
`else
  assign elig_s  = req;
  assign timeout = 1'b0;
`endif

  assign found_s = |elig_s;
  assign gnt     = gnt_r;
  assign rd_data = RAM_Do;

  // Round-robin pick: first eligible requester scanning upward from rr_ptr_r.
  always_comb begin
    pick_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pick_s = elig_s[wrap_add(rr_ptr_r, k)] ? wrap_add(rr_ptr_r, k) : pick_s;
    end
  end

  // Next-state and next-grant logic of the arbitration FSM.
  always_comb begin
    state_n = state_r;
    gnt_n   = '0;
    owner_n = owner_r;
    rr_n    = rr_ptr_r;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_n = hold_cnt_r;
    timeout_n  = 1'b0;
    blocked_n  = blocked_r & req;
`endif
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_n = ST_GRANT;
          owner_n = pick_s;
          gnt_n   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[owner_r]) begin
          state_n = ST_HANDOVER;
          rr_n    = wrap_add(owner_r, 1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_r == CNT_W'(MAX_HOLD - 1)) begin
          // Requester held too long: revoke and keep it out until it lets go.
          state_n            = ST_HANDOVER;
          rr_n               = wrap_add(owner_r, 1);
          timeout_n          = 1'b1;
          blocked_n[owner_r] = 1'b1;
        end
`endif
        else begin
          gnt_n = gnt_r;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = hold_cnt_r + CNT_W'(1);
`endif
        end
      end
      ST_HANDOVER: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      gnt_r    <= '0;
      owner_r  <= '0;
      rr_ptr_r <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_r <= '0;
      blocked_r  <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      gnt_r    <= gnt_n;
      owner_r  <= owner_n;
      rr_ptr_r <= rr_n;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_r <= hold_cnt_n;
      blocked_r  <= blocked_n;
      timeout_r  <= timeout_n;
`endif
    end
  end

  // RAM port mux: the granted requester drives the RAM, otherwise it is idle.
  always_comb begin
    RAM_EN = 1'b0;
    RAM_A  = '0;
    RAM_WE = 4'h0;
    RAM_Di = 32'h0;
    if (|gnt_r) begin
      RAM_EN = req_en[owner_r];
      RAM_A  = req_a[int'(owner_r)*ADDR_WIDTH +: ADDR_WIDTH];
      RAM_WE = req_we[int'(owner_r)*4 +: 4];
      RAM_Di = req_di[int'(owner_r)*32 +: 32];
    end else begin
      RAM_EN = 1'b0;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port 32-bit RAM port (EN, A, WE, Di, Do) between NUM_REQ engines, e.g. host loader, subdivision engine and RAM-to-RAM copy engine.
- Grants are round-robin and held for a whole transaction: a requester keeps req high for the duration of its burst.
- The arbiter muxes the granted requester's port signals onto the RAM and forces the RAM idle otherwise.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 9, RAM address width.
- MAX_HOLD, 1024, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- gnt  out  NUM_REQ  one-hot grant; all zero when nobody is granted.
- req_en  in  NUM_REQ  per-requester RAM enable.
- req_a  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i is requester i.
- req_we  in  NUM_REQ*4  per-requester byte write enables.
- req_di  in  NUM_REQ*32  per-requester write data.
- RAM_EN  out  1  RAM enable.
- RAM_A  out  ADDR_WIDTH  RAM address.
- RAM_WE  out  4  RAM byte write enables.
- RAM_Di  out  32  RAM write data.
- RAM_Do  in  32  RAM read data.
- rd_data  out  32  RAM_Do broadcast to all requesters, combinational passthrough.
- timeout  out  1  one-cycle pulse when a grant is revoked; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- States:
  - IDLE: no grant.
  - GRANT: gnt[owner]=1.
  - HANDOVER: one dead cycle, no grant.
- Reset, applied at the clock edge while rst=1:
  - state=IDLE, gnt=0, owner=0, rr pointer=0 (requester 0 highest priority), hold counter=0, timeout=0, blocked flags=0.
  - RAM outputs then follow the mux rule below, i.e. RAM_EN=0, RAM_WE=0, RAM_A=0, RAM_Di=0.
- Reset mid-grant: gnt drops at that edge with no handover cycle. The RAM sees EN=0 and WE=0 from the cycle after the edge.
- IDLE -> GRANT:
  - Taken on the first edge where any eligible req is high.
  - Owner = first eligible requester found scanning upward from the rr pointer, modulo NUM_REQ.
  - gnt is registered: req rising before edge k gives gnt high after edge k, i.e. 1-cycle latency.
  - Eligible means req high and blocked flag clear.
- GRANT -> HANDOVER: when req[owner] is sampled low. gnt clears at that edge and rr pointer = (owner+1) mod NUM_REQ.
- HANDOVER -> IDLE: unconditionally after one cycle. Back-to-back grants are therefore separated by at least 2 idle cycles (HANDOVER, then IDLE).
- Simultaneous requests: the round-robin scan decides. A requester that was just served has the lowest priority at the next arbitration.
- A req that falls before being granted is simply not granted; there is no latching.
- RAM mux (combinational):
  - When gnt[i]=1: RAM_EN=req_en[i], RAM_A, RAM_WE and RAM_Di take slice i.
  - When no grant: RAM_EN=0, RAM_WE=0, RAM_A=0, RAM_Di=0.
  - Ungranted requesters' port signals are ignored entirely and never reach the RAM.
- Requesters must not drive writes before seeing gnt. The arbiter does not buffer accesses.
- Read latency is set by the RAM and is not added to by the arbiter.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entering GRANT and increments each GRANT cycle.
  - If the counter reaches MAX_HOLD-1 while req[owner] is still high, the next edge forces HANDOVER: gnt clears, timeout=1 for exactly that one cycle, and the rr pointer advances past the owner.
  - The owner's blocked flag is set, and clears only when its req is sampled low. This stops a stuck requester from re-winning immediately.
- Undefined: no counter, no blocked flags, timeout tied 0, and grants are unbounded.

Test Plan:
- Reset, then req=3'b001, req_en[0]=1, req_a[0]=9'h005, req_we[0]=4'hF, req_di[0]=32'hDEADBEEF -> gnt=3'b001 one cycle after req; RAM_A=9'h005, RAM_WE=4'hF, RAM_Di=32'hDEADBEEF; after req drops, gnt=0 and RAM_EN=0.
- req=3'b111 held continuously, each requester dropping req 4 cycles after its grant -> grant order 0,1,2,0; at least 2 idle cycles with RAM_EN=0 between consecutive grants.
- Requester 1 granted while requester 2 drives req_we[2]=4'hF, req_a[2]=9'h1FF -> RAM_WE and RAM_A follow requester 1 only; RAM address 9'h1FF is never written.
- rst asserted for 1 cycle mid-grant of requester 2 -> gnt=0, RAM_EN=0 and RAM_WE=0 after that edge; with req=3'b110 and req[0]=0 after reset, requester 1 wins (pointer=0, scan order 0,1,2).
- ARB_TIMEOUT_EN, MAX_HOLD=16, req[0] stuck high, req[1] high -> gnt[0] lasts exactly 16 cycles; timeout pulses 1 cycle; requester 1 granted next; requester 0 not re-granted until it drops req and raises it again.
- ARB_TIMEOUT_EN undefined, req[0] high for 2000 cycles -> gnt[0] held for all 2000 cycles; timeout stays 0.
